// File: rtl/kalman_sequencer.sv
// kalman_sequencer
//   Sequences one Kalman filter update per IMU sample: a roll/pitch step,
//   then (on every YAW_DIV-th sample) a yaw step. Each step is issued with a
//   one-cycle enable, waits for kalman_done from the filter timer, then
//   clears the timer. One further sample may queue (pending) while busy;
//   any more are dropped and flagged in sticky sample_overrun.
//
//   Optional feature: define KALMAN_SEQ_TIMEOUT_EN to build an 8-bit
//   kalman_done watchdog (TIMEOUT_CYCLES). On expiry it pulses timeout_err,
//   clears the timer in ABORT and returns to IDLE. When the macro is not
//   defined, WAIT states wait forever and timeout_err is tied to 0.
//
// Parameters
//   YAW_DIV         1..16   yaw step on every YAW_DIV-th sample
//   TIMEOUT_CYCLES  2..255  watchdog limit (only with KALMAN_SEQ_TIMEOUT_EN)
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   sample_ready         in   1-cycle pulse, new IMU sample
//   kalman_done          in   step finished, held until timer_clear
//   overrun_clear        in   clears sample_overrun
//   roll_pitch_enable    out  1-cycle roll/pitch step request
//   yaw_enable           out  1-cycle yaw step request
//   timer_clear          out  1-cycle filter timer clear
//   update_busy          out  high whenever not IDLE
//   update_done          out  1-cycle pulse, update for one sample finished
//   sample_overrun       out  sticky, a sample was dropped
//   timeout_err          out  1-cycle pulse, watchdog expired
module kalman_sequencer #(
  parameter int YAW_DIV        = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_ready,
  input  logic kalman_done,
  input  logic overrun_clear,
  output logic roll_pitch_enable,
  output logic yaw_enable,
  output logic timer_clear,
  output logic update_busy,
  output logic update_done,
  output logic sample_overrun,
  output logic timeout_err
);

  typedef enum logic [3:0] {
    IDLE, RP_ISSUE, RP_WAIT, RP_CLR, YAW_ISSUE, YAW_WAIT, YAW_CLR, DONE, ABORT
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] yaw_cnt;
  logic       pending, pending_nxt;
  logic       overrun_set;
  logic       wd_expire;

`ifdef KALMAN_SEQ_TIMEOUT_EN
  logic [7:0] wdog;
  logic       wait_st;

  assign wait_st   = (state == RP_WAIT) || (state == YAW_WAIT);
  // A done arriving in the expiry cycle still wins over the watchdog.
  assign wd_expire = wait_st && !kalman_done && (wdog >= 8'(TIMEOUT_CYCLES));

  // ISSUE always precedes WAIT, so zeroing there means 0 on WAIT entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wdog <= '0;
    else if (state == RP_ISSUE || state == YAW_ISSUE)
      wdog <= '0;
    else if (wait_st && !kalman_done && !wd_expire)
      wdog <= wdog + 8'd1;
  end
`else
  // Watchdog not built: TIMEOUT_CYCLES has no effect in this configuration.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign wd_expire          = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (sample_ready) state_nxt = RP_ISSUE;
      RP_ISSUE:  state_nxt = RP_WAIT;
      RP_WAIT:   if (kalman_done) state_nxt = RP_CLR;
                 else if (wd_expire) state_nxt = ABORT;
      RP_CLR:    state_nxt = (yaw_cnt == 4'd0) ? YAW_ISSUE : DONE;
      YAW_ISSUE: state_nxt = YAW_WAIT;
      YAW_WAIT:  if (kalman_done) state_nxt = YAW_CLR;
                 else if (wd_expire) state_nxt = ABORT;
      YAW_CLR:   state_nxt = DONE;
      DONE:      state_nxt = (pending || sample_ready) ? RP_ISSUE : IDLE;
      ABORT:     state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    roll_pitch_enable = (state == RP_ISSUE);
    yaw_enable        = (state == YAW_ISSUE);
    timer_clear       = (state == RP_CLR) || (state == YAW_CLR) || (state == ABORT);
    update_busy       = (state != IDLE);
    update_done       = (state == DONE);
    timeout_err       = wd_expire;
  end

  // Pending / overrun. In DONE a waiting sample is consumed; a sample
  // arriving in the same cycle either starts directly (nothing pending) or
  // becomes the new pending one, so DONE never drops a sample.
  always_comb begin
    pending_nxt = pending;
    overrun_set = 1'b0;
    if (state == DONE) begin
      pending_nxt = pending && sample_ready;
    end else if (state != IDLE && sample_ready) begin
      overrun_set = pending;
      pending_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending        <= 1'b0;
      sample_overrun <= 1'b0;
      yaw_cnt        <= 4'd0;
    end else begin
      pending <= pending_nxt;
      if (overrun_set)        sample_overrun <= 1'b1;
      else if (overrun_clear) sample_overrun <= 1'b0;
      if (state == DONE)
        yaw_cnt <= (yaw_cnt == 4'(YAW_DIV - 1)) ? 4'd0 : yaw_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_kalman_sequencer.sv
// tb_kalman_sequencer
//   Bench for kalman_sequencer (YAW_DIV=3, TIMEOUT_CYCLES=20). A responder
//   models the filter timer: kalman_done rises resp_lat cycles after an
//   enable and falls on timer_clear. Event cycles are logged relative to a
//   run's cycle 0 and compared against fixed timelines and, for random
//   sample streams, against a per-sample timeline model.
module tb_kalman_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sample_ready = 1'b0, kalman_done = 1'b0, overrun_clear = 1'b0;
  logic roll_pitch_enable, yaw_enable, timer_clear, update_busy;
  logic update_done, sample_overrun, timeout_err;

  always #5 clk = ~clk;

  kalman_sequencer #(.YAW_DIV(3), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .sample_ready(sample_ready), .kalman_done(kalman_done),
    .overrun_clear(overrun_clear), .roll_pitch_enable(roll_pitch_enable),
    .yaw_enable(yaw_enable), .timer_clear(timer_clear), .update_busy(update_busy),
    .update_done(update_done), .sample_overrun(sample_overrun), .timeout_err(timeout_err)
  );

  int errors = 0, checks = 0;
  int cyc = 0, base = 0;
  int q_rp[$], q_yaw[$], q_tc[$], q_done[$], q_to[$];
  bit both_seen;
  bit resp_en = 1'b1;
  int resp_lat = 10, resp_t = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor first, then responder, in one block so neither races the other.
  always @(negedge clk) begin
    if (rst) begin
      kalman_done = 1'b0;
      resp_t = 0;
    end else begin
      if (roll_pitch_enable) q_rp.push_back(cyc - base);
      if (yaw_enable)        q_yaw.push_back(cyc - base);
      if (timer_clear)       q_tc.push_back(cyc - base);
      if (update_done)       q_done.push_back(cyc - base);
      if (timeout_err)       q_to.push_back(cyc - base);
      if (roll_pitch_enable && yaw_enable) both_seen = 1'b1;
      if (timer_clear) kalman_done = 1'b0;
      if (resp_en && (roll_pitch_enable || yaw_enable)) resp_t = resp_lat;
      else if (resp_t > 0) begin
        resp_t--;
        if (resp_t == 0) kalman_done = 1'b1;
      end
    end
  end

  function automatic string q2s(input int q[$]);
    string s = "";
    foreach (q[i]) s = (i == 0) ? $sformatf("%0d", q[i]) : {s, ",", $sformatf("%0d", q[i])};
    return s;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; sample_ready = 1'b0; overrun_clear = 1'b0; resp_en = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
  endtask

  // Marks the current cycle as cycle 0 of a run.
  task automatic start_run();
    @(posedge clk); #1;
    base = cyc;
    q_rp.delete(); q_yaw.delete(); q_tc.delete(); q_done.delete(); q_to.delete();
    both_seen = 1'b0;
  endtask

  task automatic pulse_sr();
    sample_ready = 1'b1;
    wait_cycles(1);
    sample_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] outs;
    rst = 1'b1;
    wait_cycles(2);
    outs = {roll_pitch_enable, yaw_enable, timer_clear, update_busy, update_done, sample_overrun, timeout_err};
    checks++;
    if (outs !== 7'b0) begin errors++; $display("FAIL reset_outs: got %b want 0000000", outs); end
    rst = 1'b0;
    wait_cycles(3);
    checks++;
    if (update_busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", update_busy); end
  endtask

  task automatic test_basic_timing();
    do_reset();
    resp_lat = 10;
    start_run();
    pulse_sr();
    wait_cycles(32);
    checks++; if (q2s(q_rp) != "1")     begin errors++; $display("FAIL basic_rp: got [%s] want [1]", q2s(q_rp)); end
    checks++; if (q2s(q_tc) != "12,24") begin errors++; $display("FAIL basic_tc: got [%s] want [12,24]", q2s(q_tc)); end
    checks++; if (q2s(q_yaw) != "13")   begin errors++; $display("FAIL basic_yaw: got [%s] want [13]", q2s(q_yaw)); end
    checks++; if (q2s(q_done) != "25")  begin errors++; $display("FAIL basic_done: got [%s] want [25]", q2s(q_done)); end
    checks++; if (update_busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got %b want 0", update_busy); end
  endtask

  task automatic test_yaw_div();
    do_reset();
    resp_lat = 3;
    start_run();
    for (int i = 0; i < 3; i++) begin
      pulse_sr();
      wait_cycles(29);
    end
    checks++; if (q2s(q_rp) != "1,31,61")    begin errors++; $display("FAIL yawdiv_rp: got [%s] want [1,31,61]", q2s(q_rp)); end
    checks++; if (q2s(q_yaw) != "6")         begin errors++; $display("FAIL yawdiv_yaw: got [%s] want [6]", q2s(q_yaw)); end
    checks++; if (q2s(q_done) != "11,36,66") begin errors++; $display("FAIL yawdiv_done: got [%s] want [11,36,66]", q2s(q_done)); end
  endtask

  task automatic test_overrun();
    do_reset();
    resp_lat = 5;
    start_run();
    pulse_sr();            // cycle 0: starts the update
    wait_cycles(2);
    pulse_sr();            // cycle 3: becomes pending
    wait_cycles(1);
    pulse_sr();            // cycle 5: dropped
    wait_cycles(1);
    pulse_sr();            // cycle 7: dropped
    wait_cycles(25);
    checks++; if (q2s(q_rp) != "1,16")    begin errors++; $display("FAIL ovr_rp: got [%s] want [1,16]", q2s(q_rp)); end
    checks++; if (q2s(q_yaw) != "8")      begin errors++; $display("FAIL ovr_yaw: got [%s] want [8]", q2s(q_yaw)); end
    checks++; if (q2s(q_done) != "15,23") begin errors++; $display("FAIL ovr_done: got [%s] want [15,23]", q2s(q_done)); end
    checks++; if (sample_overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", sample_overrun); end
    overrun_clear = 1'b1;
    wait_cycles(1);
    overrun_clear = 1'b0;
    checks++; if (sample_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", sample_overrun); end
    checks++; if (both_seen) begin errors++; $display("FAIL ovr_excl: got rp&yaw together want never"); end
  endtask

  task automatic test_timeout();
    do_reset();
    resp_en = 1'b0;
    start_run();
    pulse_sr();
    wait_cycles(40);
`ifdef KALMAN_SEQ_TIMEOUT_EN
    checks++; if (q2s(q_to) != "22")   begin errors++; $display("FAIL to_err: got [%s] want [22]", q2s(q_to)); end
    checks++; if (q2s(q_tc) != "23")   begin errors++; $display("FAIL to_tc: got [%s] want [23]", q2s(q_tc)); end
    checks++; if (update_busy !== 1'b0) begin errors++; $display("FAIL to_idle: got %b want 0", update_busy); end
`else
    checks++; if (q2s(q_to) != "")     begin errors++; $display("FAIL to_none: got [%s] want []", q2s(q_to)); end
    checks++; if (q2s(q_tc) != "")     begin errors++; $display("FAIL to_tc_none: got [%s] want []", q2s(q_tc)); end
    checks++; if (update_busy !== 1'b1) begin errors++; $display("FAIL to_wait: got %b want 1", update_busy); end
`endif
    do_reset();
  endtask

  task automatic test_reset_mid();
    logic [6:0] outs;
    do_reset();
    resp_lat = 10;
    start_run();
    pulse_sr();
    wait_cycles(14);       // cycle 15: inside YAW_WAIT
    checks++; if (update_busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b want 1", update_busy); end
    #2 rst = 1'b1;
    #1;
    outs = {roll_pitch_enable, yaw_enable, timer_clear, update_busy, update_done, sample_overrun, timeout_err};
    checks++; if (outs !== 7'b0) begin errors++; $display("FAIL rstmid_outs: got %b want 0000000", outs); end
    wait_cycles(1);
    rst = 1'b0;
    q_tc.delete(); q_rp.delete();
    wait_cycles(3);
    checks++; if (q_tc.size() + q_rp.size() != 0) begin errors++; $display("FAIL rstmid_quiet: got %0d events want 0", q_tc.size() + q_rp.size()); end
    start_run();
    pulse_sr();
    wait_cycles(30);
    checks++; if (q2s(q_rp) != "1")     begin errors++; $display("FAIL rstmid_rp: got [%s] want [1]", q2s(q_rp)); end
    checks++; if (q2s(q_yaw) != "13")   begin errors++; $display("FAIL rstmid_yaw: got [%s] want [13]", q2s(q_yaw)); end
    checks++; if (q2s(q_done) != "25")  begin errors++; $display("FAIL rstmid_done: got [%s] want [25]", q2s(q_done)); end
  endtask

  // Random sample streams against a per-sample timeline model: an update
  // started in cycle s finishes (DONE) at s+L+2, or s+2L+4 with a yaw step
  // (yaw enable at s+L+2); yaw on every third update since reset. One
  // sample can wait while busy; further ones are dropped.
  task automatic test_random();
    bit sr_at[0:249];
    int exp_rp[$], exp_yaw[$], exp_done[$];
    bit act, pend, ovr, go;
    int d, k, t, l;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      l = $urandom_range(1, 6);
      resp_lat = l;
      foreach (sr_at[i]) sr_at[i] = 1'b0;
      t = 0;
      for (int n = 0; n < int'($urandom_range(6, 14)); n++) begin
        t += $urandom_range(1, 4 * l + 8);
        if (t < 160) sr_at[t] = 1'b1;
      end
      exp_rp.delete(); exp_yaw.delete(); exp_done.delete();
      act = 0; pend = 0; ovr = 0; d = -1; k = 0;
      for (int c = 0; c < 250; c++) begin
        go = 0;
        if (act && c == d) begin
          exp_done.push_back(c);
          if (pend || sr_at[c]) go = 1; else act = 0;
          pend = pend && sr_at[c];
        end else if (act) begin
          if (sr_at[c]) begin
            if (pend) ovr = 1;
            pend = 1;
          end
        end else if (sr_at[c]) go = 1;
        if (go) begin
          act = 1;
          exp_rp.push_back(c + 1);
          if (k % 3 == 0) begin
            exp_yaw.push_back(c + 1 + l + 2);
            d = c + 1 + 2 * l + 4;
          end else d = c + 1 + l + 2;
          k++;
        end
      end
      start_run();
      for (int c = 0; c < 250; c++) begin
        sample_ready = sr_at[c];
        wait_cycles(1);
      end
      sample_ready = 1'b0;
      checks++; if (q2s(q_rp) != q2s(exp_rp))     begin errors++; $display("FAIL rnd%0d_rp: got [%s] want [%s]", it, q2s(q_rp), q2s(exp_rp)); end
      checks++; if (q2s(q_yaw) != q2s(exp_yaw))   begin errors++; $display("FAIL rnd%0d_yaw: got [%s] want [%s]", it, q2s(q_yaw), q2s(exp_yaw)); end
      checks++; if (q2s(q_done) != q2s(exp_done)) begin errors++; $display("FAIL rnd%0d_done: got [%s] want [%s]", it, q2s(q_done), q2s(exp_done)); end
      checks++; if (sample_overrun !== ovr)       begin errors++; $display("FAIL rnd%0d_ovr: got %b want %b", it, sample_overrun, ovr); end
      checks++; if (both_seen)                    begin errors++; $display("FAIL rnd%0d_excl: got rp&yaw together want never", it); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_timing();
    test_yaw_div();
    test_overrun();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout: got no finish want finish before 1ms");
    $fatal(1, "simulation time limit");
  end
endmodule

// File: doc/kalman_sequencer.md
KALMAN_SEQUENCER -- requirements
Module: kalman_sequencer

Interface
REQ-001 SHALL have parameter YAW_DIV, default 1: yaw update issued on every YAW_DIV-th sample; legal range 1..16.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64: kalman_done watchdog limit; legal range 2..255.
REQ-003 SHALL have port: clk  in  1  system clock; all logic on rising edge.
REQ-004 SHALL have port: rst  in  1  reset; asynchronous, active-high.
REQ-005 SHALL have port: sample_ready  in  1  one-cycle pulse; new IMU sample available.
REQ-006 SHALL have port: kalman_done  in  1  from the filter timer; high once a step completes, held until timer_clear.
REQ-007 SHALL have port: overrun_clear  in  1  clears sample_overrun.
REQ-008 SHALL have port: roll_pitch_enable  out  1  one-cycle request for a roll/pitch step.
REQ-009 SHALL have port: yaw_enable  out  1  one-cycle request for a yaw step.
REQ-010 SHALL have port: timer_clear  out  1  one-cycle clear of the filter timer.
REQ-011 SHALL have port: update_busy  out  1  high in every state except IDLE.
REQ-012 SHALL have port: update_done  out  1  one-cycle pulse; full update for one sample finished.
REQ-013 SHALL have port: sample_overrun  out  1  sticky; a sample was dropped.
REQ-014 SHALL have port: timeout_err  out  1  one-cycle pulse; watchdog expired.

Function
REQ-015 SHALL implement states IDLE, RP_ISSUE, RP_WAIT, RP_CLR, YAW_ISSUE, YAW_WAIT, YAW_CLR, DONE, ABORT.
REQ-016 SHALL go IDLE->RP_ISSUE on the edge sampling sample_ready=1, so roll_pitch_enable is high in the next cycle (latency 1).
REQ-017 SHALL assert roll_pitch_enable only in RP_ISSUE and yaw_enable only in YAW_ISSUE; both SHALL never be high together.
REQ-018 SHALL move RP_ISSUE->RP_WAIT and YAW_ISSUE->YAW_WAIT unconditionally after 1 cycle; kalman_done is ignored in ISSUE states.
REQ-019 SHALL move RP_WAIT->RP_CLR and YAW_WAIT->YAW_CLR when kalman_done=1; timer_clear is high for exactly the 1 CLR cycle.
REQ-020 SHALL move RP_CLR->YAW_ISSUE when yaw_cnt==0, else RP_CLR->DONE; YAW_CLR->DONE always.
REQ-021 SHALL keep 4-bit yaw_cnt: increments in DONE, wraps from YAW_DIV-1 to 0; with YAW_DIV=1 it stays 0.
REQ-022 SHALL pulse update_done in DONE; DONE->RP_ISSUE if pending or sample_ready, else DONE->IDLE.
REQ-023 SHALL set a 1-bit pending flag on sample_ready in any state other than IDLE; pending is consumed on DONE->RP_ISSUE.
REQ-024 SHALL set sample_overrun when sample_ready arrives while pending=1 and pending is not consumed that cycle; the new sample is dropped.
REQ-025 SHALL, in DONE with pending=1 and sample_ready=1, consume pending, keep pending=1 for the new sample, and not set overrun.
REQ-026 SHALL clear sample_overrun on overrun_clear=1; a simultaneous set wins.

Reset
REQ-027 SHALL on rst=1 force state IDLE, yaw_cnt=0, pending=0, watchdog=0, and all outputs 0, immediately and independent of clk.
REQ-028 SHALL, when rst is released mid-update, start from IDLE; no timer_clear is issued for the aborted step.

Configuration
REQ-029 SHALL, with KALMAN_SEQ_TIMEOUT_EN defined, run an 8-bit watchdog: zeroed on entry to RP_WAIT and YAW_WAIT, incremented each cycle in a WAIT state with kalman_done=0.
REQ-030 SHALL, with KALMAN_SEQ_TIMEOUT_EN defined, on watchdog reaching TIMEOUT_CYCLES, pulse timeout_err and go to ABORT (timer_clear=1 for 1 cycle), then IDLE; pending is kept and yaw_cnt is unchanged.
REQ-031 SHALL, with KALMAN_SEQ_TIMEOUT_EN undefined, wait indefinitely in WAIT states, tie timeout_err to 0, keep the port, and make ABORT unreachable.

Verification
REQ-032 SHALL cover: YAW_DIV=1, responder asserts done 10 cycles after each enable; sample_ready at cycle 0 -> rp_enable at c1, timer_clear at c12, yaw_enable at c13, timer_clear at c24, update_done at c25.
REQ-033 SHALL cover: YAW_DIV=3, 3 spaced samples -> yaw_enable only on sample 1 (yaw_cnt 0), update_done for each sample, no yaw_enable on samples 2 and 3.
REQ-034 SHALL cover: 3 sample_ready pulses during one update -> one pending serviced right after DONE, sample_overrun=1; overrun_clear -> 0.
REQ-035 SHALL cover: macro defined, TIMEOUT_CYCLES=20, done never asserted -> timeout_err pulse 20 cycles after RP_WAIT entry, timer_clear next cycle, then IDLE; macro undefined -> update_busy stays 1.
REQ-036 SHALL cover: rst asserted in YAW_WAIT -> all outputs 0 at once; next sample_ready issues roll_pitch_enable 1 cycle later with yaw (yaw_cnt=0).
